tq_fdct_4x4_seq: RTL and testbench
==================================

# tq_fdct_4x4_seq

Row-serial forward 4x4 integer core transform for the dct_quant path. It is the forward counterpart of the inverse core transform. Residual rows enter one per handshake, and a horizontal butterfly is applied on entry. Results are stored in a transpose bank, and the vertical butterfly is applied on read-out. One column of 4 unscaled coefficients leaves per handshake, toward quantisation.

## Interface
Parameters:
- IN_WIDTH, 9: signed residual width.
- OUT_WIDTH, IN_WIDTH+6: signed coefficient width. The transform gain is at most 36, so no overflow is possible.

Ports:
- clk  in  1  clock; the only clock. The design has one clock. Reset is synchronous and active-low.
- rst_n  in  1  synchronous active-low reset, sampled on rising clk.
- in_valid_i  in  1  input row valid.
- in_ready_o  out  1  input row accepted when in_valid_i & in_ready_o.
- in_row_i  in  4*IN_WIDTH  residuals x[r][0..3]; element 0 is in the LSBs.
- out_valid_o  out  1  coefficient column valid.
- out_ready_i  in  1  column consumed when out_valid_o & out_ready_i.
- out_col_o  out  4*OUT_WIDTH  Y[0..3][c]; element 0 is in the LSBs.
- out_idx_o  out  2  column index c of the current beat.
- out_last_o  out  1  high with out_valid_o when c==3.

## Operation
Horizontal butterfly on in_row_i. Operands are sign-extended to IN_WIDTH+3 bits.
- a=s0+s3, b=s1+s2, e=s0-s3, f=s1-s2.
- h0=a+b, h1=2e+f, h2=a-b, h3=e-2f.

Bank write:
- Row r (0..3) of h is written into the write bank at the accepting edge.
- A 2-bit row counter tracks r. On the 4th row the bank is marked full, the counter wraps to 0 and the write-bank pointer toggles.

Vertical butterfly:
- Applied combinationally to column c of the read bank: s_k = h[k][c].
- Same equations as the horizontal butterfly, at OUT_WIDTH.
- Drives out_col_o, giving Y[0..3][c].
- Arithmetic is exact two's complement with no rounding or shift.

Read-out:
- A 2-bit column counter c advances on each output handshake.
- On the c==3 handshake the read bank is marked empty, c wraps to 0 and the read-bank pointer toggles.

Handshake signals:
- in_ready_o = !full[wr_bank].
- out_valid_o = full[rd_bank].
- out_col_o, out_idx_o and out_last_o are forced to 0 while out_valid_o is 0.

Boundary conditions:
- A write that fills one bank and a last-column read that drains the other, on the same edge, both take effect.
- Held output (out_ready_i low) keeps out_col_o, out_idx_o and out_last_o stable.
- Row 4 of a block completes only on its own handshake. in_valid_i gaps between rows are allowed, and the row counter holds through them.

Reset values (rst_n low at an edge): in_ready_o=1, out_valid_o=0, out_col_o=0, out_idx_o=0, out_last_o=0. Both counters, both full flags and both bank pointers clear. A partially received or partially drained block is discarded.

## Timing
- Latency: out_valid_o rises in the cycle after the edge that accepts row 3.
- Beat c=0 is presented in that cycle.
- Minimum block period is 4 cycles in and 4 cycles out (ping-pong).
- out_valid_o and in_ready_o are both registered-flag functions, with no combinational path from in_valid_i or out_ready_i.
- The first edge after rst_n returns high can accept a row.

## Configuration
- TQ_FDCT_PINGPONG_EN defined: two banks as described. Input and output overlap, so sustained throughput is one row in and one column out per cycle.
- Undefined: a single bank, and both pointers are tied to 0.
  - in_ready_o is low from the cycle after row 3 is accepted until the cycle after the c==3 handshake.
  - Sustained period is 8 cycles per block.
  - All other behaviour is identical.

## Test plan
- All residuals =1, one block:
  - beat 0 = {16,0,0,0}.
  - beats 1-3 = all zero.
  - out_last_o only on beat 3.
  - out_valid_o rises 1 cycle after row 3 is accepted.
- Impulse x[0][0]=1, others 0:
  - beat 0 = {1,2,1,1}.
  - beat 1 = {2,4,2,2}.
  - beat 2 = {1,2,1,1}.
  - beat 3 = {1,2,1,1}.
- Extremes:
  - All x = -255: Y[0][0] = -4080, all other coefficients 0.
  - Rows 0 and 1 = {255,255,-255,-255}, rows 2 and 3 = {-255,-255,255,255}: Y[1][1] = 9180 (beat 1, element 1), which proves no overflow at OUT_WIDTH=15.
- Backpressure: out_ready_i low for 5 cycles at beat 2.
  - Outputs are held, with out_idx_o = 2.
  - With the macro, the next block's 4 rows are accepted, then in_ready_o stays low until the first block drains.
- Back-to-back: 3 blocks, in_valid_i and out_ready_i held high.
  - With the macro, in_ready_o never drops, and the 12 beats appear in cycles 4-15.
  - Without the macro, in_ready_o is low in cycles 4-7.
- Reset mid-block: 2 rows accepted, then rst_n low for 1 cycle, then a full all-ones block.
  - Exactly 4 beats are produced, equal to the all-ones result.

Source files
------------

// File: rtl/tq_fdct_4x4_seq_if.sv
// Row-in / column-out stream bundle for the 4x4 forward core transform.
// The transform block sits on the slave modport; the row source and column sink sit on master.
interface tq_fdct_4x4_seq_if #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = IN_WIDTH + 6
);
    logic                   in_valid_i;
    logic                   in_ready_o;
    logic [4*IN_WIDTH-1:0]  in_row_i;
    logic                   out_valid_o;
    logic                   out_ready_i;
    logic [4*OUT_WIDTH-1:0] out_col_o;
    logic [1:0]             out_idx_o;
    logic                   out_last_o;

    modport master (
        output in_valid_i, in_row_i, out_ready_i,
        input  in_ready_o, out_valid_o, out_col_o, out_idx_o, out_last_o
    );

    modport slave (
        input  in_valid_i, in_row_i, out_ready_i,
        output in_ready_o, out_valid_o, out_col_o, out_idx_o, out_last_o
    );
endinterface

// File: rtl/tq_fdct_4x4_seq.sv
// Row-serial forward 4x4 integer core transform: horizontal butterfly on row entry, transpose bank,
// vertical butterfly on column read-out. Define TQ_FDCT_PINGPONG_EN for two overlapping banks.
module tq_fdct_4x4_seq #(
    parameter int IN_WIDTH  = 9,
    parameter int OUT_WIDTH = IN_WIDTH + 6
) (
    input logic               clk,
    input logic               rst_n,
    tq_fdct_4x4_seq_if.slave  bus
);
    localparam int H_W = IN_WIDTH + 3;
`ifdef TQ_FDCT_PINGPONG_EN
    localparam int NUM_BANKS = 2;
`else
    localparam int NUM_BANKS = 1;
`endif

    function automatic logic signed [H_W-1:0] sext_h(input logic [IN_WIDTH-1:0] v);
        return {{(H_W-IN_WIDTH){v[IN_WIDTH-1]}}, v};
    endfunction

    function automatic logic signed [OUT_WIDTH-1:0] sext_o(input logic [H_W-1:0] v);
        return {{(OUT_WIDTH-H_W){v[H_W-1]}}, v};
    endfunction

    logic [1:0]           row_cnt;
    logic [1:0]           col_cnt;
    logic [NUM_BANKS-1:0] full;
    logic [NUM_BANKS-1:0] full_nxt;
    logic                 wr_bank;
    logic                 rd_bank;
    logic                 in_fire;
    logic                 out_fire;

    logic signed [H_W-1:0] bank_mem [NUM_BANKS][4][4];

    // Horizontal butterfly on the incoming row.
    logic signed [H_W-1:0] s [4];
    logic signed [H_W-1:0] h [4];
    logic signed [H_W-1:0] ha, hb, he, hf;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            s[k] = sext_h(bus.in_row_i[k*IN_WIDTH +: IN_WIDTH]);
        end
        ha   = s[0] + s[3];
        hb   = s[1] + s[2];
        he   = s[0] - s[3];
        hf   = s[1] - s[2];
        h[0] = ha + hb;
        h[1] = (he <<< 1) + hf;
        h[2] = ha - hb;
        h[3] = he - (hf <<< 1);
    end

    // Vertical butterfly on column col_cnt of the read bank.
    logic signed [OUT_WIDTH-1:0] v [4];
    logic signed [OUT_WIDTH-1:0] y [4];
    logic signed [OUT_WIDTH-1:0] va, vb, ve, vf;

    always_comb begin
        for (int k = 0; k < 4; k++) begin
            v[k] = sext_o(bank_mem[rd_bank][k][col_cnt]);
        end
        va   = v[0] + v[3];
        vb   = v[1] + v[2];
        ve   = v[0] - v[3];
        vf   = v[1] - v[2];
        y[0] = va + vb;
        y[1] = (ve <<< 1) + vf;
        y[2] = va - vb;
        y[3] = ve - (vf <<< 1);
    end

    assign bus.in_ready_o  = !full[wr_bank];
    assign bus.out_valid_o = full[rd_bank];
    assign in_fire         = bus.in_valid_i && bus.in_ready_o;
    assign out_fire        = bus.out_valid_o && bus.out_ready_i;

    assign bus.out_col_o  = bus.out_valid_o ? {y[3], y[2], y[1], y[0]} : '0;
    assign bus.out_idx_o  = bus.out_valid_o ? col_cnt : 2'd0;
    assign bus.out_last_o = bus.out_valid_o && (col_cnt == 2'd3);

    // Drain is applied before fill so a same-edge fill and drain both land, whichever banks they hit.
    always_comb begin
        full_nxt = full;
        if (out_fire && col_cnt == 2'd3) full_nxt[rd_bank] = 1'b0;
        if (in_fire && row_cnt == 2'd3)  full_nxt[wr_bank] = 1'b1;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            row_cnt <= 2'd0;
            col_cnt <= 2'd0;
            full    <= '0;
        end else begin
            full <= full_nxt;
            if (in_fire)  row_cnt <= row_cnt + 2'd1;
            if (out_fire) col_cnt <= col_cnt + 2'd1;
        end
    end

`ifdef TQ_FDCT_PINGPONG_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
        end else begin
            if (in_fire && row_cnt == 2'd3)  wr_bank <= !wr_bank;
            if (out_fire && col_cnt == 2'd3) rd_bank <= !rd_bank;
        end
    end
`else
    assign wr_bank = 1'b0;
    assign rd_bank = 1'b0;
`endif

    // NOTE: the transpose bank has no reset; the full flags decide whether its contents are ever read.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int k = 0; k < 4; k++) begin
                bank_mem[wr_bank][row_cnt][k] <= h[k];
            end
        end
    end

endmodule

// File: tb/tb_tq_fdct_4x4_seq.sv
// Scoreboard bench for tq_fdct_4x4_seq: drivers push hand-computed beats, a monitor pops on handshakes.
// Behaviour-dependent checks follow TQ_FDCT_PINGPONG_EN the same way the design does.
module tb_tq_fdct_4x4_seq;
    localparam int IW = 9;
    localparam int OW = 15;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    tq_fdct_4x4_seq_if #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) bus ();

    tq_fdct_4x4_seq #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    typedef enum {BLK_ONES, BLK_IMP, BLK_NEG, BLK_EXT} blk_e;

    typedef struct packed {
        logic [4*OW-1:0] col;
        logic [1:0]      idx;
        logic            last;
    } beat_t;

    beat_t exp_q[$];
    int    n_checks = 0;
    int    n_errors = 0;
    int    n_beats  = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [4*OW-1:0] mk_col(input int y0, input int y1, input int y2, input int y3);
        logic signed [OW-1:0] t0, t1, t2, t3;
        t0 = OW'(y0);
        t1 = OW'(y1);
        t2 = OW'(y2);
        t3 = OW'(y3);
        return {t3, t2, t1, t0};
    endfunction

    function automatic logic [4*IW-1:0] mk_row(input int x0, input int x1, input int x2, input int x3);
        logic signed [IW-1:0] t0, t1, t2, t3;
        t0 = IW'(x0);
        t1 = IW'(x1);
        t2 = IW'(x2);
        t3 = IW'(x3);
        return {t3, t2, t1, t0};
    endfunction

    function automatic logic [4*IW-1:0] get_row(input blk_e b, input int r);
        case (b)
            BLK_ONES: return mk_row(1, 1, 1, 1);
            BLK_IMP:  return (r == 0) ? mk_row(1, 0, 0, 0) : mk_row(0, 0, 0, 0);
            BLK_NEG:  return mk_row(-255, -255, -255, -255);
            default:  return (r < 2) ? mk_row(255, 255, -255, -255) : mk_row(-255, -255, 255, 255);
        endcase
    endfunction

    task automatic push_beat(input int idx, input logic [4*OW-1:0] col);
        beat_t e;
        e.col  = col;
        e.idx  = 2'(idx);
        e.last = (idx == 3);
        exp_q.push_back(e);
    endtask

    // Hand-derived coefficient columns for each directed block.
    task automatic expect_block(input blk_e b);
        case (b)
            BLK_ONES: begin
                push_beat(0, mk_col(16, 0, 0, 0));
                push_beat(1, mk_col(0, 0, 0, 0));
                push_beat(2, mk_col(0, 0, 0, 0));
                push_beat(3, mk_col(0, 0, 0, 0));
            end
            BLK_IMP: begin
                push_beat(0, mk_col(1, 2, 1, 1));
                push_beat(1, mk_col(2, 4, 2, 2));
                push_beat(2, mk_col(1, 2, 1, 1));
                push_beat(3, mk_col(1, 2, 1, 1));
            end
            BLK_NEG: begin
                push_beat(0, mk_col(-4080, 0, 0, 0));
                push_beat(1, mk_col(0, 0, 0, 0));
                push_beat(2, mk_col(0, 0, 0, 0));
                push_beat(3, mk_col(0, 0, 0, 0));
            end
            default: begin
                push_beat(0, mk_col(0, 0, 0, 0));
                push_beat(1, mk_col(0, 9180, 0, -3060));
                push_beat(2, mk_col(0, 0, 0, 0));
                push_beat(3, mk_col(0, -3060, 0, 1020));
            end
        endcase
    endtask

    // Entered and left at posedge+1; returns right after the accepting edge.
    task automatic send_row(input logic [4*IW-1:0] row);
        int waited;
        waited         = 0;
        bus.in_valid_i = 1'b1;
        bus.in_row_i   = row;
        forever begin
            @(negedge clk);
            if (bus.in_ready_o) break;
            waited++;
            if (waited > 200) begin
                n_checks++;
                n_errors++;
                $display("FAIL in_ready_timeout: in_ready_o stayed 0 for %0d cycles", waited);
                break;
            end
        end
        @(posedge clk);
        #1;
        bus.in_valid_i = 1'b0;
    endtask

    task automatic send_block(input blk_e b);
        expect_block(b);
        for (int r = 0; r < 4; r++) send_row(get_row(b, r));
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid_o) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: %0d beats still pending", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_in_ready"},  64'(bus.in_ready_o),  64'd1);
        check({tag, "_out_valid"}, 64'(bus.out_valid_o), 64'd0);
        check({tag, "_out_col"},   64'(bus.out_col_o),   64'd0);
        check({tag, "_out_idx"},   64'(bus.out_idx_o),   64'd0);
        check({tag, "_out_last"},  64'(bus.out_last_o),  64'd0);
    endtask

    // Monitor: every output handshake pops one expected beat.
    always @(negedge clk) begin
        beat_t e;
        if (rst_n && bus.out_valid_o && bus.out_ready_i) begin
            n_beats++;
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_beat: got col %0h idx %0d with nothing expected",
                         bus.out_col_o, bus.out_idx_o);
            end else begin
                e = exp_q.pop_front();
                check("beat_col",  64'(bus.out_col_o),  64'(e.col));
                check("beat_idx",  64'(bus.out_idx_o),  64'(e.idx));
                check("beat_last", 64'(bus.out_last_o), 64'(e.last));
            end
        end
    end

    initial begin
        #200000;
        n_errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        bus.in_valid_i  = 1'b0;
        bus.in_row_i    = '0;
        bus.out_ready_i = 1'b1;
        rst_n           = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // All ones, with first-block latency.
        expect_block(BLK_ONES);
        for (int r = 0; r < 4; r++) begin
            if (r == 3) check("latency_before_row3", 64'(bus.out_valid_o), 64'd0);
            send_row(get_row(BLK_ONES, r));
        end
        check("latency_after_row3", 64'(bus.out_valid_o), 64'd1);
        wait_drain();

        send_block(BLK_IMP);
        wait_drain();
        send_block(BLK_NEG);
        wait_drain();
        send_block(BLK_EXT);
        wait_drain();

        // Backpressure: hold beat 2 for 5 cycles.
        fork
            begin
                send_block(BLK_IMP);
`ifdef TQ_FDCT_PINGPONG_EN
                send_block(BLK_ONES);
                check("bp_in_ready_low", 64'(bus.in_ready_o), 64'd0);
`endif
            end
            begin
                int budget;
                budget = 0;
                forever begin
                    @(posedge clk);
                    #1;
                    if (bus.out_valid_o && bus.out_idx_o == 2'd2) break;
                    budget++;
                    if (budget > 100) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL bp_beat2_timeout: beat 2 never presented");
                        break;
                    end
                end
                bus.out_ready_i = 1'b0;
                repeat (5) begin
                    @(negedge clk);
                    check("hold_valid", 64'(bus.out_valid_o), 64'd1);
                    check("hold_idx",   64'(bus.out_idx_o),   64'd2);
                    check("hold_col",   64'(bus.out_col_o),   64'(mk_col(1, 2, 1, 1)));
                    check("hold_last",  64'(bus.out_last_o),  64'd0);
                end
                @(posedge clk);
                #1;
                bus.out_ready_i = 1'b1;
            end
        join
`ifndef TQ_FDCT_PINGPONG_EN
        send_block(BLK_ONES);
`endif
        wait_drain();

        // Back-to-back: three blocks with valid and ready held high.
        fork
            begin
                send_block(BLK_NEG);
                send_block(BLK_EXT);
                send_block(BLK_IMP);
            end
            begin
                for (int k = 0; k < 16; k++) begin
                    logic exp_valid;
                    logic exp_ready;
                    @(negedge clk);
`ifdef TQ_FDCT_PINGPONG_EN
                    exp_valid = (k >= 4);
                    exp_ready = 1'b1;
`else
                    exp_valid = (k >= 4 && k <= 7) || (k >= 12);
                    exp_ready = (k < 4) || (k >= 8);
`endif
                    check($sformatf("b2b_valid_c%0d", k), 64'(bus.out_valid_o), 64'(exp_valid));
                    if (k < 12) check($sformatf("b2b_ready_c%0d", k), 64'(bus.in_ready_o), 64'(exp_ready));
                end
            end
        join
        wait_drain();

        // Reset mid-block: two rows discarded, then a clean all-ones block.
        send_row(get_row(BLK_ONES, 0));
        send_row(get_row(BLK_ONES, 1));
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_reset_outputs("midrst");
        rst_n = 1'b1;
        send_block(BLK_ONES);
        wait_drain();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        check("beat_count",  64'(n_beats),      64'd40);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
